mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared Mem geometry and arbiter FSM state encoding
package mem_pkg;

   localparam int MEM_ADDR_BITS = 10;
   localparam int MEM_DATA_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - stateless 2-way round-robin picker
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   // With no request the index is a don't-care; 0 keeps it deterministic.
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin Mem arbiter with whole-memory clear
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_BITS = MEM_ADDR_BITS,
   parameter int DATA_BITS = MEM_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic [ADDR_BITS-1:0] p0_addr,
   input  logic [DATA_BITS-1:0] p0_wdata,
   output logic                 p0_gnt,
   output logic                 p0_done,
   output logic [DATA_BITS-1:0] p0_rdata,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic [ADDR_BITS-1:0] p1_addr,
   input  logic [DATA_BITS-1:0] p1_wdata,
   output logic                 p1_gnt,
   output logic                 p1_done,
   output logic [DATA_BITS-1:0] p1_rdata,
   input  logic                 clr_req,
   output logic                 clr_done,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 mem_sel,
   output logic                 mem_str,
   output logic                 mem_ld,
   output logic                 mem_clr,
   input  logic [DATA_BITS-1:0] mem_rdata,
   output logic                 busy
);

   state_e               state_q, state_d;
   logic                 last_grant_q, last_grant_d;
   logic                 port_q, port_d;
   logic                 we_q, we_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [DATA_BITS-1:0] wdata_q, wdata_d;
   logic [1:0]           gnt_q, gnt_d;
   logic [1:0]           done_q, done_d;
   logic                 clr_done_q, clr_done_d;
   logic                 mem_sel_q, mem_sel_d;
   logic                 mem_str_q, mem_str_d;
   logic                 mem_ld_q, mem_ld_d;
   logic                 mem_clr_q, mem_clr_d;
   logic                 pick;

   rr_arb2 u_rr_arb2 (
      .req        ({p1_req, p0_req}),
      .last_grant (last_grant_q),
      .grant      (pick)
   );

   // Strobes and pulses are computed one state ahead so every output is a flop.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      gnt_d        = 2'b00;
      done_d       = 2'b00;
      clr_done_d   = 1'b0;
      mem_sel_d    = 1'b0;
      mem_str_d    = 1'b0;
      mem_ld_d     = 1'b0;
      mem_clr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               state_d   = ST_CLEAR;
               mem_clr_d = 1'b1;
            end else if (p0_req || p1_req) begin
               state_d      = ST_ISSUE;
               port_d       = pick;
               last_grant_d = pick;
               we_d         = pick ? p1_we    : p0_we;
               addr_d       = pick ? p1_addr  : p0_addr;
               wdata_d      = pick ? p1_wdata : p0_wdata;
               gnt_d[pick]  = 1'b1;
               mem_sel_d    = 1'b1;
               mem_str_d    = we_d;
               mem_ld_d     = ~we_d;
            end
         end
         ST_ISSUE: begin
            state_d        = ST_DONE;
            done_d[port_q] = 1'b1;
         end
         ST_CLEAR: begin
            state_d    = ST_DONE;
            clr_done_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         gnt_q        <= 2'b00;
         done_q       <= 2'b00;
         clr_done_q   <= 1'b0;
         mem_sel_q    <= 1'b0;
         mem_str_q    <= 1'b0;
         mem_ld_q     <= 1'b0;
         mem_clr_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         gnt_q        <= gnt_d;
         done_q       <= done_d;
         clr_done_q   <= clr_done_d;
         mem_sel_q    <= mem_sel_d;
         mem_str_q    <= mem_str_d;
         mem_ld_q     <= mem_ld_d;
         mem_clr_q    <= mem_clr_d;
      end
   end

   assign p0_gnt    = gnt_q[0];
   assign p1_gnt    = gnt_q[1];
   assign p0_done   = done_q[0];
   assign p1_done   = done_q[1];
   assign clr_done  = clr_done_q;
   assign p0_rdata  = (done_q[0] && !we_q) ? mem_rdata : '0;
   assign p1_rdata  = (done_q[1] && !we_q) ? mem_rdata : '0;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_sel   = mem_sel_q;
   assign mem_str   = mem_str_q;
   assign mem_ld    = mem_ld_q;
   assign mem_clr   = mem_clr_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
